// File: rtl/sw_debounce8.sv
// Switch conditioner: 2-flop sync, shared-tick debounce, edge/changed strobes for 8 requests + enable.
// Latency: raw edge to x_out/en_out between (STABLE_CNT-1)*TICK_DIV+3 and STABLE_CNT*TICK_DIV+3 cycles; rise/changed one cycle later.
// Backpressure: none; level outputs are always valid and pulses are not held for a consumer.
module sw_debounce8 #(
    parameter int TICK_DIV   = 1000,
    parameter int STABLE_CNT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw_in,
    input  logic       en_in,
    output logic [7:0] x_out,
    output logic       en_out,
    output logic [7:0] rise,
    output logic       changed
);

    // Channel 8 is the enable switch; all nine channels share identical logic.
    localparam int NCH   = 9;
    localparam int CNT_W = $clog2(STABLE_CNT) + 1;
    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   sync1_q;
    logic [NCH-1:0]   sync2_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             tick;
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];
    logic [NCH-1:0]   stable_q;
    logic [NCH-1:0]   stable_d;
    logic [NCH-1:0]   prev_q;
    logic [7:0]       rise_q;
    logic [7:0]       rise_d;
    logic             changed_q;
    logic             changed_d;

    assign raw = {en_in, sw_in};

    // Two-flop synchroniser per channel; sync2_q is the clean sampled level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Free-running sample divider; with TICK_DIV=1 the compare is always true.
    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // Divider register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Per-channel agreement counter: any agreeing sample clears progress, STABLE_CNT disagreeing ticks flip.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick) begin
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Counter and stable-level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            stable_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            stable_q <= stable_d;
        end
    end

    // Strobes compare the stable level with its one-cycle-old copy, so they trail x_out by a cycle.
    always_comb begin
        rise_d    = stable_q[7:0] & ~prev_q[7:0];
        changed_d = |(stable_q ^ prev_q);
    end

    // Strobe registers; reset clears prev_q together with stable_q so a reset never fakes an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            rise_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            prev_q    <= stable_q;
            rise_q    <= rise_d;
            changed_q <= changed_d;
        end
    end

    assign x_out   = stable_q[7:0];
    assign en_out  = stable_q[8];
    assign rise    = rise_q;
    assign changed = changed_q;

endmodule
